// File: rtl/axi_lite_txn_scheduler_pkg.sv
// Shared AXI-lite helper types: response codes, channel bit positions and scheduler state/request types.
package axi_helper;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  localparam int TX_EN_AW = 4;
  localparam int TX_EN_W  = 3;
  localparam int TX_EN_AR = 1;
  localparam int RX_B     = 2;
  localparam int RX_R     = 0;

  // Request fields are sized for the widest supported bus; users slice down to their width.
  localparam int SCHED_MAX_ADDR_W = 64;
  localparam int SCHED_MAX_DATA_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_B,
    WAIT_R,
    RESP
  } sched_state_t;

  typedef struct packed {
    logic                        write;
    logic [SCHED_MAX_ADDR_W-1:0] addr;
    logic [SCHED_MAX_DATA_W-1:0] wdata;
  } sched_req_t;

endpackage

// File: rtl/axi_lite_txn_scheduler_if.sv
// Requester, channel-engine launch and completion signals of the AXI-lite transaction scheduler.
interface axi_lite_txn_scheduler_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]         rsp_rdata;
  logic [1:0]                rsp_resp;
  logic [4:0]                tx_en;
  logic [ADDR_W-1:0]         tx_addr;
  logic [DATA_W-1:0]         tx_wdata;
  logic                      aw_hold;
  logic                      w_hold;
  logic                      ar_hold;
  logic [4:0]                new_data;
  logic [1:0]                bresp;
  logic [DATA_W-1:0]         rdata;
  logic [1:0]                rresp;
  logic                      r_hold;
  logic                      busy;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  aw_hold, w_hold, ar_hold, new_data, bresp, rdata, rresp,
    output req_ready, rsp_valid, rsp_rdata, rsp_resp,
    output tx_en, tx_addr, tx_wdata, r_hold, busy
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output aw_hold, w_hold, ar_hold, new_data, bresp, rdata, rresp,
    input  req_ready, rsp_valid, rsp_rdata, rsp_resp,
    input  tx_en, tx_addr, tx_wdata, r_hold, busy
  );

endinterface

// File: rtl/axi_lite_txn_scheduler_rr_arbiter.sv
// Round-robin requester selection, searching upward from the slot after 'last' with wrap.
// Latency: purely combinational, no state.
// Backpressure: grants nothing while 'advance' is low.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic                 advance,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(N);

  int   cand;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int off = 1; off <= N; off++) begin
      cand = int'(last) + off;
      if (cand >= N) cand = cand - N;
      if (advance && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/axi_lite_txn_scheduler.sv
// Round-robin AXI-lite transaction scheduler: one outstanding beat, launch pulses to AW/W/AR, B/R completion return.
// Latency: grant -> launch 1 cycle; completion pulse -> rsp_valid 1 cycle; rsp_ready -> IDLE 1 cycle.
// Backpressure: launch waits on engine hold signals; rsp_valid stays up until the owner's rsp_ready.
module axi_lite_txn_scheduler
  import axi_helper::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 256
) (
  input logic                     ACLK,
  input logic                     ARESET,
  axi_lite_txn_scheduler_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);

  sched_state_t       state, state_nxt;
  sched_req_t         cur;
  logic [IDX_W-1:0]   owner, last_grant, grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic               any_grant;
  logic [WD_W-1:0]    wd;
  logic [DATA_W-1:0]  rdata_q;
  resp_t              resp_q;
  logic               expire;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req       (bus.req_valid),
    .advance   (state == IDLE),
    .last      (last_grant),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign any_grant = |grant;
  assign expire    = (TIMEOUT > 0) && (wd == WD_LAST);

  assign bus.req_ready = grant;
  assign bus.rsp_valid = (state == RESP) ? (NUM_REQ'(1) << owner) : '0;
  assign bus.rsp_rdata = (state == RESP) ? rdata_q : '0;
  assign bus.rsp_resp  = (state == RESP) ? resp_q : RESP_OKAY;
  assign bus.tx_addr   = cur.addr[ADDR_W-1:0];
  assign bus.tx_wdata  = cur.wdata[DATA_W-1:0];
  assign bus.r_hold    = (state == RESP) && !cur.write;
  assign bus.busy      = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    bus.tx_en  = '0;
    case (state)
      IDLE:   if (any_grant) state_nxt = ISSUE;
      ISSUE: begin
        if (cur.write) begin
          if (!bus.aw_hold && !bus.w_hold) begin
            bus.tx_en[TX_EN_AW] = 1'b1;
            bus.tx_en[TX_EN_W]  = 1'b1;
            state_nxt           = WAIT_B;
          end
        end else if (!bus.ar_hold) begin
          bus.tx_en[TX_EN_AR] = 1'b1;
          state_nxt           = WAIT_R;
        end
      end
      WAIT_B: if (bus.new_data[RX_B] || expire) state_nxt = RESP;
      WAIT_R: if (bus.new_data[RX_R] || expire) state_nxt = RESP;
      RESP:   if (bus.rsp_ready[owner]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state      <= IDLE;
      last_grant <= IDX_W'(NUM_REQ - 1);
      owner      <= '0;
      cur        <= '0;
      wd         <= '0;
      rdata_q    <= '0;
      resp_q     <= RESP_OKAY;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (any_grant) begin
          owner      <= grant_idx;
          last_grant <= grant_idx;
          cur.write  <= bus.req_write[grant_idx];
          cur.addr   <= SCHED_MAX_ADDR_W'(bus.req_addr[int'(grant_idx)*ADDR_W +: ADDR_W]);
          cur.wdata  <= SCHED_MAX_DATA_W'(bus.req_wdata[int'(grant_idx)*DATA_W +: DATA_W]);
        end
        ISSUE: wd <= '0;
        // A real completion takes precedence over a watchdog expiry in the same cycle.
        WAIT_B: begin
          if (bus.new_data[RX_B]) begin
            rdata_q <= '0;
            resp_q  <= bus.bresp;
          end else if (expire) begin
            rdata_q <= '0;
            resp_q  <= RESP_SLVERR;
          end else if (TIMEOUT > 0 && wd != WD_MAX) begin
            wd <= wd + 1'b1;
          end
        end
        WAIT_R: begin
          if (bus.new_data[RX_R]) begin
            rdata_q <= bus.rdata;
            resp_q  <= bus.rresp;
          end else if (expire) begin
            rdata_q <= '0;
            resp_q  <= RESP_SLVERR;
          end else if (TIMEOUT > 0 && wd != WD_MAX) begin
            wd <= wd + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_txn_scheduler.sv
// Directed bench for axi_lite_txn_scheduler with TIMEOUT=8 and two requesters.
module tb_axi_lite_txn_scheduler;

  logic aclk;
  logic arst;
  int   n_checks;
  int   n_fail;

  axi_lite_txn_scheduler_if #(.ADDR_W(32), .DATA_W(32), .NUM_REQ(2)) bus ();

  axi_lite_txn_scheduler #(.ADDR_W(32), .DATA_W(32), .NUM_REQ(2), .TIMEOUT(8)) dut (
    .ACLK   (aclk),
    .ARESET (arst),
    .bus    (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic nxt();
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    arst = 1'b1;
    nxt();
    nxt();
    @(negedge aclk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.tx_en !== 5'b0) begin n_fail++; $display("FAIL rst_tx_en: got %b want 00000", bus.tx_en); end
    n_checks++; if (bus.rsp_valid !== 2'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 00", bus.rsp_valid); end
    n_checks++; if (bus.req_ready !== 2'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b want 00", bus.req_ready); end
    n_checks++; if (bus.r_hold !== 1'b0) begin n_fail++; $display("FAIL rst_r_hold: got %b want 0", bus.r_hold); end
    n_checks++; if (bus.tx_addr !== 32'h0) begin n_fail++; $display("FAIL rst_tx_addr: got %h want 0", bus.tx_addr); end
    nxt();
    arst = 1'b0;
  endtask

  task automatic test_single_write();
    bus.req_valid = 2'b01; bus.req_write = 2'b01;
    bus.req_addr  = {32'h0, 32'h10}; bus.req_wdata = {32'h0, 32'hDEADBEEF};
    @(negedge aclk);
    n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL wr_grant: got %b want 01", bus.req_ready); end
    nxt(); bus.req_valid = 2'b00;
    @(negedge aclk);
    n_checks++; if (bus.tx_en !== 5'b11000) begin n_fail++; $display("FAIL wr_tx_en: got %b want 11000", bus.tx_en); end
    n_checks++; if (bus.tx_addr !== 32'h10) begin n_fail++; $display("FAIL wr_tx_addr: got %h want 10", bus.tx_addr); end
    n_checks++; if (bus.tx_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_tx_wdata: got %h want deadbeef", bus.tx_wdata); end
    n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL wr_ready_issue: got %b want 00", bus.req_ready); end
    nxt();
    @(negedge aclk);
    n_checks++; if (bus.tx_en !== 5'b0) begin n_fail++; $display("FAIL wr_tx_en_once: got %b want 00000", bus.tx_en); end
    nxt(); bus.new_data = 5'b00100; bus.bresp = 2'b00;
    @(negedge aclk);
    n_checks++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL wr_rsp_early: got %b want 00", bus.rsp_valid); end
    nxt(); bus.new_data = 5'b0; bus.rsp_ready = 2'b01;
    @(negedge aclk);
    n_checks++; if (bus.rsp_valid !== 2'b01) begin n_fail++; $display("FAIL wr_rsp_valid: got %b want 01", bus.rsp_valid); end
    n_checks++; if (bus.rsp_resp !== 2'b00) begin n_fail++; $display("FAIL wr_rsp_resp: got %b want 00", bus.rsp_resp); end
    n_checks++; if (bus.r_hold !== 1'b0) begin n_fail++; $display("FAIL wr_r_hold: got %b want 0", bus.r_hold); end
    nxt(); bus.rsp_ready = 2'b00;
    @(negedge aclk);
    n_checks++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL wr_rsp_drop: got %b want 00", bus.rsp_valid); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL wr_idle: busy=%b want 0", bus.busy); end
    nxt();
  endtask

  task automatic test_single_read();
    bus.req_valid = 2'b10; bus.req_write = 2'b00;
    bus.req_addr  = {32'h20, 32'h0};
    @(negedge aclk);
    n_checks++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL rd_grant: got %b want 10", bus.req_ready); end
    nxt(); bus.req_valid = 2'b00;
    @(negedge aclk);
    n_checks++; if (bus.tx_en !== 5'b00010) begin n_fail++; $display("FAIL rd_tx_en: got %b want 00010", bus.tx_en); end
    n_checks++; if (bus.tx_addr !== 32'h20) begin n_fail++; $display("FAIL rd_tx_addr: got %h want 20", bus.tx_addr); end
    nxt(); bus.new_data = 5'b00001; bus.rdata = 32'h12345678; bus.rresp = 2'b00;
    @(negedge aclk);
    n_checks++; if (bus.tx_en !== 5'b0) begin n_fail++; $display("FAIL rd_tx_en_once: got %b want 00000", bus.tx_en); end
    nxt(); bus.new_data = 5'b0; bus.rdata = 32'h0;
    @(negedge aclk);
    n_checks++; if (bus.rsp_valid !== 2'b10) begin n_fail++; $display("FAIL rd_rsp_valid: got %b want 10", bus.rsp_valid); end
    n_checks++; if (bus.rsp_rdata !== 32'h12345678) begin n_fail++; $display("FAIL rd_rsp_rdata: got %h want 12345678", bus.rsp_rdata); end
    n_checks++; if (bus.r_hold !== 1'b1) begin n_fail++; $display("FAIL rd_r_hold: got %b want 1", bus.r_hold); end
    nxt(); bus.rsp_ready = 2'b10;
    @(negedge aclk);
    n_checks++; if (bus.r_hold !== 1'b1) begin n_fail++; $display("FAIL rd_r_hold_wait: got %b want 1", bus.r_hold); end
    n_checks++; if (bus.rsp_valid !== 2'b10) begin n_fail++; $display("FAIL rd_rsp_hold: got %b want 10", bus.rsp_valid); end
    nxt(); bus.rsp_ready = 2'b00;
    @(negedge aclk);
    n_checks++; if (bus.r_hold !== 1'b0) begin n_fail++; $display("FAIL rd_r_hold_rel: got %b want 0", bus.r_hold); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rd_idle: busy=%b want 0", bus.busy); end
    nxt();
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_grant;
    logic [31:0] exp_addr;
    bus.req_valid = 2'b11; bus.req_write = 2'b00;
    bus.req_addr  = {32'h200, 32'h100};
    bus.rsp_ready = 2'b11;
    for (int t = 0; t < 4; t++) begin
      exp_grant = (t % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr  = (t % 2 == 0) ? 32'h100 : 32'h200;
      @(negedge aclk);
      n_checks++; if (bus.req_ready !== exp_grant) begin n_fail++; $display("FAIL rr_grant%0d: got %b want %b", t, bus.req_ready, exp_grant); end
      nxt();
      @(negedge aclk);
      n_checks++; if (bus.tx_addr !== exp_addr) begin n_fail++; $display("FAIL rr_addr%0d: got %h want %h", t, bus.tx_addr, exp_addr); end
      nxt(); bus.new_data = 5'b00001; bus.rdata = 32'hA000 + 32'(t);
      nxt(); bus.new_data = 5'b0;
      @(negedge aclk);
      n_checks++; if (bus.rsp_valid !== exp_grant) begin n_fail++; $display("FAIL rr_rsp%0d: got %b want %b", t, bus.rsp_valid, exp_grant); end
      n_checks++; if (bus.rsp_rdata !== 32'hA000 + 32'(t)) begin n_fail++; $display("FAIL rr_rdata%0d: got %h want %h", t, bus.rsp_rdata, 32'hA000 + 32'(t)); end
      nxt();
    end
    bus.req_valid = 2'b00; bus.rsp_ready = 2'b00;
    nxt();
  endtask

  task automatic test_engine_stall();
    bus.req_valid = 2'b01; bus.req_write = 2'b00;
    bus.req_addr  = {32'h0, 32'h30}; bus.ar_hold = 1'b1;
    @(negedge aclk);
    n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL st_grant: got %b want 01", bus.req_ready); end
    nxt(); bus.req_valid = 2'b00;
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      n_checks++; if (bus.tx_en !== 5'b0) begin n_fail++; $display("FAIL st_early%0d: got %b want 00000", c, bus.tx_en); end
      nxt();
    end
    bus.ar_hold = 1'b0;
    @(negedge aclk);
    n_checks++; if (bus.tx_en !== 5'b00010) begin n_fail++; $display("FAIL st_launch: got %b want 00010", bus.tx_en); end
    nxt(); bus.new_data = 5'b00001; bus.rdata = 32'h55;
    nxt(); bus.new_data = 5'b0; bus.rsp_ready = 2'b01;
    @(negedge aclk);
    n_checks++; if (bus.rsp_rdata !== 32'h55) begin n_fail++; $display("FAIL st_rdata: got %h want 55", bus.rsp_rdata); end
    nxt(); bus.rsp_ready = 2'b00;
    nxt();
  endtask

  task automatic test_timeout();
    bus.req_valid = 2'b10; bus.req_write = 2'b10;
    bus.req_addr  = {32'h40, 32'h0}; bus.req_wdata = {32'hCAFE, 32'h0};
    bus.w_hold    = 1'b1;
    @(negedge aclk);
    n_checks++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL to_grant: got %b want 10", bus.req_ready); end
    nxt(); bus.req_valid = 2'b00;
    @(negedge aclk);
    n_checks++; if (bus.tx_en !== 5'b0) begin n_fail++; $display("FAIL to_w_hold: got %b want 00000", bus.tx_en); end
    nxt(); bus.w_hold = 1'b0; bus.aw_hold = 1'b1;
    @(negedge aclk);
    n_checks++; if (bus.tx_en !== 5'b0) begin n_fail++; $display("FAIL to_aw_hold: got %b want 00000", bus.tx_en); end
    nxt(); bus.aw_hold = 1'b0;
    @(negedge aclk);
    n_checks++; if (bus.tx_en !== 5'b11000) begin n_fail++; $display("FAIL to_launch: got %b want 11000", bus.tx_en); end
    n_checks++; if (bus.tx_wdata !== 32'hCAFE) begin n_fail++; $display("FAIL to_wdata: got %h want cafe", bus.tx_wdata); end
    nxt();
    for (int c = 0; c < 8; c++) begin
      @(negedge aclk);
      n_checks++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL to_wait%0d: got %b want 00", c, bus.rsp_valid); end
      nxt();
    end
    bus.new_data = 5'b00100; bus.bresp = 2'b01;
    @(negedge aclk);
    n_checks++; if (bus.rsp_valid !== 2'b10) begin n_fail++; $display("FAIL to_rsp_valid: got %b want 10", bus.rsp_valid); end
    n_checks++; if (bus.rsp_resp !== 2'b10) begin n_fail++; $display("FAIL to_slverr: got %b want 10", bus.rsp_resp); end
    n_checks++; if (bus.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL to_rdata: got %h want 0", bus.rsp_rdata); end
    nxt(); bus.new_data = 5'b0; bus.bresp = 2'b00; bus.rsp_ready = 2'b10;
    @(negedge aclk);
    n_checks++; if (bus.rsp_resp !== 2'b10) begin n_fail++; $display("FAIL to_late_ignored: got %b want 10", bus.rsp_resp); end
    nxt(); bus.rsp_ready = 2'b00;
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      n_checks++; if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL to_no_second%0d: rsp_valid=%b busy=%b want 00/0", c, bus.rsp_valid, bus.busy); end
      nxt();
    end
  endtask

  task automatic test_reset_mid();
    bus.req_valid = 2'b01; bus.req_write = 2'b00;
    bus.req_addr  = {32'h0, 32'h50};
    @(negedge aclk);
    n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL rm_grant: got %b want 01", bus.req_ready); end
    nxt(); bus.req_valid = 2'b00;
    nxt();
    @(negedge aclk);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rm_wait: busy=%b want 1", bus.busy); end
    nxt(); arst = 1'b1;
    nxt(); arst = 1'b0;
    bus.new_data = 5'b00001; bus.rdata = 32'h99;
    @(negedge aclk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rm_idle: busy=%b want 0", bus.busy); end
    n_checks++; if (bus.tx_addr !== 32'h0) begin n_fail++; $display("FAIL rm_tx_addr: got %h want 0", bus.tx_addr); end
    n_checks++; if (bus.rsp_valid !== 2'b00 || bus.r_hold !== 1'b0) begin n_fail++; $display("FAIL rm_outputs: rsp_valid=%b r_hold=%b want 00/0", bus.rsp_valid, bus.r_hold); end
    nxt(); bus.new_data = 5'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      n_checks++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rm_no_rsp%0d: got %b want 00", c, bus.rsp_valid); end
      nxt();
    end
    bus.req_valid = 2'b11;
    @(negedge aclk);
    n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL rm_prio: got %b want 01", bus.req_ready); end
    nxt(); bus.req_valid = 2'b00;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    arst = 1'b1;
    bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.rsp_ready = '0; bus.aw_hold = 1'b0; bus.w_hold = 1'b0; bus.ar_hold = 1'b0;
    bus.new_data = '0; bus.bresp = '0; bus.rdata = '0; bus.rresp = '0;
    test_reset();
    test_single_write();
    test_single_read();
    test_round_robin();
    test_engine_stall();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
